// File: rtl/addsub_rr_arbiter.sv
// Round-robin front end that shares one 4-bit adder/subtractor among N_REQ requesters.
// One operation in flight: accept in IDLE, compute in EXEC, hold the response in RESP.
module addsub_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_m,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_sum,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] op_id;
    logic             found_hi;
    logic             found_lo;
    logic             accept;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;
    logic             sel_m;
    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic             op_m;
    logic [3:0]       beff;
    logic [3:0]       alu_sum;
    logic             alu_carry;
    logic             alu_ovf;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = IDX_W'(i);
                if (i >= int'(rr_ptr)) begin
                    found_hi = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        grant_idx = found_hi ? hi_idx : lo_idx;
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_m = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_a = req_a[4*i +: 4];
                sel_b = req_b[4*i +: 4];
                sel_m = req_m[i];
            end
        end
    end

    // Next state and the combinational accept pulse; rst suppresses a grant that would be dropped.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found_lo && !rst) begin
                    accept               = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Subtract is A + ~B + 1; the carry-in is the mode bit.
    always_comb begin
        beff                 = op_b ^ {4{op_m}};
        {alu_carry, alu_sum} = 5'(op_a) + 5'(beff) + 5'(op_m);
        alu_ovf              = (op_a[3] == beff[3]) && (alu_sum[3] != op_a[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_m      <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_m   <= sel_m;
                op_id  <= grant_idx;
                rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : ID_W'(grant_idx + IDX_W'(1));
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= ID_W'(op_id);
                rsp_sum   <= alu_sum;
                rsp_carry <= alu_carry;
                rsp_ovf   <= alu_ovf;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Self-checking bench for addsub_rr_arbiter: directed scenarios plus randomized rounds
// compared against a transaction-level round-robin and signed/unsigned arithmetic model.
module tb_addsub_rr_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]   req_m;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [3:0]     rsp_sum;
    logic           rsp_carry;
    logic           rsp_ovf;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    logic [3:0] va[N];
    logic [3:0] vb[N];
    logic       vm[N];

    addsub_rr_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_m(req_m),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[4*i +: 4] = va[i];
            req_b[4*i +: 4] = vb[i];
            req_m[i]        = vm[i];
        end
    endtask

    task automatic reroll_op(input int i);
        va[i] = 4'($urandom);
        vb[i] = 4'($urandom);
        vm[i] = 1'($urandom);
    endtask

    // First requesting index in the order ptr, ptr+1, ... modulo N; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // {sum, carry, ovf} from plain integer arithmetic.
    function automatic logic [5:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic m);
        int ia, ib, r, sa, sb, sr;
        logic c, o;
        ia = int'(a);
        ib = int'(b);
        r  = m ? (ia - ib) : (ia + ib);
        c  = m ? (ia >= ib) : (r > 15);
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        sr = m ? (sa - sb) : (sa + sb);
        o  = (sr > 7) || (sr < -8);
        return {4'(r & 15), c, o};
    endfunction

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf, busy} !== 14'd0)
            begin errors++; $display("FAIL reset_outputs: got %b want 0",
                {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf, busy}); end
        req_valid = '0;
        rst       = 1'b0;
        m_ptr     = 0;
        tick();
    endtask

    // One IDLE arbitration cycle and, if granted, the full EXEC/RESP sequence with `stall` not-ready cycles.
    task automatic round(input logic [N-1:0] mask, input int stall, input bit reroll, output int w);
        logic [8:0]   exp_rsp;
        logic [N-1:0] exp_ready;
        req_valid = mask;
        drive_ops();
        #1;
        w         = rr_pick(mask, m_ptr);
        exp_ready = (w < 0) ? '0 : N'(1 << w);
        checks++;
        if (req_ready !== exp_ready)
            begin errors++; $display("FAIL grant: got %b want %b", req_ready, exp_ready); end
        checks++;
        if ({busy, rsp_valid} !== 2'b00)
            begin errors++; $display("FAIL idle_status: busy/valid got %b want 00", {busy, rsp_valid}); end
        if (w < 0) begin
            tick();
            return;
        end
        exp_rsp = {1'b1, 2'(w), ref_res(va[w], vb[w], vm[w])};
        m_ptr   = (w + 1) % N;
        tick();
        if (reroll) begin
            reroll_op(w);
            drive_ops();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, busy, rsp_valid} !== 6'b0000_10)
            begin errors++; $display("FAIL exec: ready/busy/valid got %b want 000010", {req_ready, busy, rsp_valid}); end
        for (int s = 0; s <= stall; s++) begin
            tick();
            rsp_ready = (s == stall);
            #1;
            checks++;
            if ({req_ready, busy} !== 5'b0000_1)
                begin errors++; $display("FAIL resp_status: ready/busy got %b want 00001", {req_ready, busy}); end
            checks++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf} !== exp_rsp)
                begin errors++; $display("FAIL resp_data: got %b want %b",
                    {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf}, exp_rsp); end
        end
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00)
            begin errors++; $display("FAIL resp_done: valid/busy got %b want 00", {rsp_valid, busy}); end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        int w;
        va[0] = 4'd3; vb[0] = 4'd5; vm[0] = 1'b0;
        round(4'b0001, 0, 1'b0, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL add_winner: got %0d want 0", w); end
    endtask

    task automatic test_sub();
        int w;
        va[2] = 4'd7; vb[2] = 4'd2; vm[2] = 1'b1;
        round(4'b0100, 0, 1'b0, w);
        va[2] = 4'd2; vb[2] = 4'd7; vm[2] = 1'b1;
        round(4'b0100, 0, 1'b0, w);
        checks++;
        if (w !== 2) begin errors++; $display("FAIL sub_winner: got %0d want 2", w); end
    endtask

    task automatic test_back_to_back();
        int w;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            round(4'b1111, 0, 1'b1, w);
            checks++;
            if (w !== i % N) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, w, i % N); end
        end
    endtask

    task automatic test_backpressure();
        int w;
        round(4'b0110, 5, 1'b1, w);
        round(4'b1001, 2, 1'b1, w);
    endtask

    task automatic test_reset_in_exec();
        int w;
        va[2] = 4'hF; vb[2] = 4'h1; vm[2] = 1'b0;
        req_valid = 4'b0100;
        drive_ops();
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL abort_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        rst       = 1'b1;
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf, busy} !== 14'd0)
            begin errors++; $display("FAIL abort_outputs: got %b want 0",
                {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf, busy}); end
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({rsp_valid, busy} !== 2'b00)
                begin errors++; $display("FAIL abort_no_rsp: valid/busy got %b want 00", {rsp_valid, busy}); end
        end
        round(4'b1010, 0, 1'b1, w);
        checks++;
        if (w !== 1) begin errors++; $display("FAIL abort_ptr: got %0d want 1", w); end
    endtask

    task automatic test_wrap();
        int w;
        round(4'b1000, 0, 1'b1, w);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL wrap_first: got %0d want 3", w); end
        round(4'b0010, 0, 1'b1, w);
        checks++;
        if (w !== 1) begin errors++; $display("FAIL wrap_second: got %0d want 1", w); end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 40; i++) begin
            round(N'($urandom), int'($urandom_range(0, 3)), 1'b1, w);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) reroll_op(i);
        drive_ops();
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_in_exec();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
